traffic_signal_monitor: RTL
===========================

// Module: traffic_signal_monitor
// PURPOSE
//  Conflict/sequence monitor on the light side of the traffic signal controller.
//  - Samples the controller's hwy/cntry light codes every clock.
//  - Checks encoding, conflicts, per-channel colour sequence, minimum yellow and all-red dwell.
//  - Latches the first fault with a code; counts completed highway cycles.
// PARAMETERS
//  CNT_W   3   width of dwell counters and of y2rdelay/r2gdelay; counters saturate at 2**CNT_W-1
//  CYC_W   8   width of cycle_count; saturates at 2**CYC_W-1
// PORTS
//  clock        in   1       single clock; all state updates on rising edge
//  clear_n      in   1       reset, asynchronous assert, active-low
//  hwy          in   2       highway light code: RED=0, YELLOW=1, GREEN=2, 3=illegal
//  cntry        in   2       country-road light code, same encoding
//  y2rdelay     in   CNT_W   minimum yellow dwell, in samples
//  r2gdelay     in   CNT_W   minimum all-red dwell before any green, in samples
//  fault_ack    in   1       clears a latched fault; ignored outside MON_FAULT
//  fault        out  1       high while a fault is latched
//  fault_code   out  3       0 none, 1 ILLEGAL_CODE, 2 CONFLICT, 3 BAD_SEQ, 4 SHORT_YELLOW, 5 SHORT_ALLRED
//  cycle_count  out  CYC_W   completed highway cycles (hwy RED->GREEN transitions)
// BEHAVIOUR
//  Reset (clear_n=0, async):
//   - fault=0, fault_code=0, cycle_count=0; all dwell counters 0; hwy_q/cntry_q=RED.
//   - FSM goes to MON_IDLE.
//  FSM MON_IDLE -> MON_RUN -> MON_FAULT:
//   - MON_IDLE: one edge; stores hwy/cntry into hwy_q/cntry_q as the baseline.
//     No checks this edge except ILLEGAL_CODE/CONFLICT. Next state MON_RUN (or MON_FAULT on violation).
//   - MON_RUN: all checks every edge; compares current inputs against hwy_q/cntry_q, then updates them.
//   - MON_FAULT: holds fault/fault_code; counters frozen.
//     fault_ack=1 at an edge clears fault and fault_code and goes to MON_IDLE (re-baseline).
//  Checks, evaluated on the sampled inputs at each edge:
//   - ILLEGAL_CODE: hwy==3 or cntry==3.
//   - CONFLICT: hwy!=RED and cntry!=RED in the same sample.
//   - BAD_SEQ: per-channel transition not in {R->R, R->G, G->G, G->Y, Y->Y, Y->R}.
//   - SHORT_YELLOW: channel Y->R while that channel's yellow count < y2rdelay.
//   - SHORT_ALLRED: any channel R->G while allred count < r2gdelay.
//  Counters (sub-module instances):
//   - Yellow count per channel: cleared on entering Y, +1 per YELLOW sample, including the first.
//   - Allred count: +1 per sample with both channels RED; cleared on any sample that is not all-red.
//   - All counters saturate, never wrap. Delay input 0 disables the matching dwell check.
//  Priority: several violations at one edge latch the lowest nonzero code (1 highest).
//  Fault latency:
//   - fault and fault_code rise at the same edge that samples the violation (1 clock after the input change).
//   - The first fault sticks; later violations do not overwrite the code.
//  cycle_count:
//   - +1 at each MON_RUN edge where hwy goes RED->GREEN with no fault at that edge.
//   - Saturates at 2**CYC_W-1; not cleared by fault_ack.
//  Simultaneous events:
//   - fault_ack with a persisting violation: ack wins. Stateless checks (codes 1, 2) re-fire at the next IDLE edge.
//   - Reset mid-dwell: discards all counts.
// STRUCTURE
//  - Shared package traffic_signal_pkg: light codes RED/YELLOW/GREEN, FSM state encodings,
//    fault code constants. The controller uses the same package.
//  - One sub-module: signal_dwell_counter (CNT_W param; clr, inc, count out; saturating).
//    Three instances: hwy yellow, cntry yellow, allred.
// TESTING
//  1 y2rdelay=3, r2gdelay=2; legal sequence hwy G,Y,Y,Y,R,R(allred x2),cntry G
//    -> fault stays 0.
//    Then hwy R->G after cntry Y,Y,Y,R and allred x2 -> cycle_count=1.
//  2 Conflict: drive hwy=GREEN, cntry=GREEN -> fault=1, fault_code=2 at next edge.
//    Then drive the same sample with hwy=3 -> fault_code stays 2 (sticky).
//  3 Sequence/dwell: hwy GREEN->RED directly -> fault_code=3.
//    After ack: hwy Y for 2 samples then R with y2rdelay=3 -> fault_code=4.
//  4 All-red: both RED for 1 sample then cntry GREEN with r2gdelay=2 -> fault_code=5.
//    Same stimulus with r2gdelay=0 -> no fault.
//  5 Priority/ack: hwy=3 and cntry=GREEN together -> fault_code=1.
//    Pulse fault_ack with inputs legal -> fault=0 next edge, MON_IDLE then MON_RUN.
//  6 Reset/saturation: assert clear_n=0 mid-yellow between edges -> outputs 0 immediately.
//    300 legal cycles -> cycle_count=255.

Source files
------------

// File: rtl/traffic_signal_pkg.sv
// Shared definitions for the traffic signal controller and its light-side
// monitor: light codes, monitor FSM states, fault codes and the per-channel
// colour transition rule.
package traffic_signal_pkg;

  localparam int NUM_CH = 2;  // channel 0 = highway, channel 1 = country road

  typedef enum logic [1:0] {
    RED     = 2'd0,
    YELLOW  = 2'd1,
    GREEN   = 2'd2,
    ILLEGAL = 2'd3
  } light_t;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_RUN   = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_t;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_ILLEGAL_CODE = 3'd1,
    FC_CONFLICT     = 3'd2,
    FC_BAD_SEQ      = 3'd3,
    FC_SHORT_YELLOW = 3'd4,
    FC_SHORT_ALLRED = 3'd5
  } fault_code_t;

  // Legal colour steps for one channel between consecutive samples.
  function automatic logic seq_ok(logic [1:0] prev, logic [1:0] cur);
    case ({prev, cur})
      {RED, RED}, {RED, GREEN}, {GREEN, GREEN},
      {GREEN, YELLOW}, {YELLOW, YELLOW}, {YELLOW, RED}: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/traffic_signal_monitor_if.sv
// Light-side bus between the signal controller (master) and the monitor (slave).
//  hwy/cntry           light codes presented by the controller
//  y2rdelay/r2gdelay   minimum yellow / all-red dwell in samples (0 disables)
//  fault_ack           clears a latched fault
//  fault/fault_code    latched fault flag and code
//  cycle_count         completed highway cycles
interface traffic_signal_monitor_if #(
  parameter int CNT_W = 3,
  parameter int CYC_W = 8
);
  logic [1:0]       hwy;
  logic [1:0]       cntry;
  logic [CNT_W-1:0] y2rdelay;
  logic [CNT_W-1:0] r2gdelay;
  logic             fault_ack;
  logic             fault;
  logic [2:0]       fault_code;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    output hwy, cntry, y2rdelay, r2gdelay, fault_ack,
    input  fault, fault_code, cycle_count
  );

  modport slave (
    input  hwy, cntry, y2rdelay, r2gdelay, fault_ack,
    output fault, fault_code, cycle_count
  );
endinterface

// File: rtl/signal_dwell_counter.sv
// Saturating dwell counter.
//  clock, clear_n  clock / async active-low reset
//  clr             restart the count this edge (with inc: count becomes 1)
//  inc             count one sample
//  count           current dwell, sticks at all-ones
module signal_dwell_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)                  count <= '0;
    else if (clr)                  count <= inc ? CNT_W'(1) : '0;
    else if (inc && count != '1)   count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/traffic_signal_monitor.sv
// Conflict / sequence monitor on the light side of the traffic controller.
// Samples hwy/cntry every clock, checks encoding, conflicts, colour sequence,
// minimum yellow and all-red dwell, latches the first fault and counts
// completed highway cycles (hwy RED->GREEN).
//  clock    single clock, rising edge
//  clear_n  async active-low reset
//  mon      light bus (slave side): inputs hwy, cntry, y2rdelay, r2gdelay,
//           fault_ack; outputs fault, fault_code, cycle_count
module traffic_signal_monitor
  import traffic_signal_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int CYC_W = 8
) (
  input  logic                     clock,
  input  logic                     clear_n,
  traffic_signal_monitor_if.slave  mon
);

  mon_state_t                       state, state_nx;
  fault_code_t                      code_q, code_nx, vcode;
  logic [CYC_W-1:0]                 cyc_q;
  logic                             cyc_inc;

  logic [NUM_CH-1:0][1:0]           cur, prev_q;
  logic [NUM_CH-1:0][CNT_W-1:0]     ycnt;
  logic [NUM_CH-1:0]                y_clr, y_inc, ill, bad, shy, g_ent;
  logic [CNT_W-1:0]                 rcnt;
  logic                             r_clr, r_inc, all_red, conflict, short_ar;
  logic                             active, idle;

  assign cur      = {mon.cntry, mon.hwy};
  assign active   = (state != MON_FAULT);  // counters and baseline frozen in fault
  assign idle     = (state == MON_IDLE);
  assign all_red  = (cur[0] == RED) && (cur[1] == RED);
  assign conflict = (cur[0] != RED) && (cur[1] != RED);

  // Per-channel checks and yellow-counter controls. The idle edge counts as
  // entering a fresh run since prev_q is not yet a valid baseline.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign ill[ch]   = (cur[ch] == ILLEGAL);
    assign bad[ch]   = !seq_ok(prev_q[ch], cur[ch]);
    // A zero delay can never exceed an unsigned count, so it disables the check.
    assign shy[ch]   = (prev_q[ch] == YELLOW) && (cur[ch] == RED) && (ycnt[ch] < mon.y2rdelay);
    assign g_ent[ch] = (prev_q[ch] == RED) && (cur[ch] == GREEN);
    assign y_inc[ch] = active && (cur[ch] == YELLOW);
    assign y_clr[ch] = active && (idle || cur[ch] != YELLOW || prev_q[ch] != YELLOW);
  end

  assign short_ar = (|g_ent) && (rcnt < mon.r2gdelay);
  assign r_inc    = active && all_red;
  assign r_clr    = active && (idle || !all_red);

  signal_dwell_counter #(.CNT_W(CNT_W)) u_ycnt [NUM_CH-1:0] (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (y_clr),
    .inc     (y_inc),
    .count   (ycnt)
  );

  signal_dwell_counter #(.CNT_W(CNT_W)) u_rcnt (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (r_clr),
    .inc     (r_inc),
    .count   (rcnt)
  );

  // Violation at this edge, lowest code wins. Only stateless checks apply
  // on the baseline (idle) edge.
  always_comb begin
    vcode = FC_NONE;
    if (|ill)            vcode = FC_ILLEGAL_CODE;
    else if (conflict)   vcode = FC_CONFLICT;
    else if (state == MON_RUN) begin
      if (|bad)          vcode = FC_BAD_SEQ;
      else if (|shy)     vcode = FC_SHORT_YELLOW;
      else if (short_ar) vcode = FC_SHORT_ALLRED;
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    cyc_inc  = 1'b0;
    unique case (state)
      MON_IDLE, MON_RUN: begin
        if (vcode != FC_NONE) begin
          state_nx = MON_FAULT;
          code_nx  = vcode;
        end else begin
          state_nx = MON_RUN;
          cyc_inc  = (state == MON_RUN) && g_ent[0];
        end
      end
      MON_FAULT: begin
        // Ack wins over any persisting violation; the idle edge re-checks.
        if (mon.fault_ack) begin
          state_nx = MON_IDLE;
          code_nx  = FC_NONE;
        end
      end
      default: state_nx = MON_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state  <= MON_IDLE;
      code_q <= FC_NONE;
      prev_q <= '0;  // RED on both channels
      cyc_q  <= '0;
    end else begin
      state  <= state_nx;
      code_q <= code_nx;
      if (active)                  prev_q <= cur;
      if (cyc_inc && cyc_q != '1)  cyc_q  <= cyc_q + CYC_W'(1);
    end
  end

  assign mon.fault       = (state == MON_FAULT);
  assign mon.fault_code  = code_q;
  assign mon.cycle_count = cyc_q;

endmodule
